// File: rtl/rv32_writeback_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rv32_writeback_unit: RV32I writeback stage driving the register-file      |
// | write port; formats load data, counts retired instructions.  Rev 1.0      |
// +---------------------------------------------------------------------------+
module rv32_writeback_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc_plus4,
  input  logic [2:0]       in_funct3,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_a3,
  output logic [31:0]      rf_wd,
  output logic             load_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  localparam int              WC_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] C_WAIT_LAST   = WC_W'(TIMEOUT - 1);
  localparam logic [1:0]      C_SEL_LOAD    = 2'b01;
  localparam logic [1:0]      C_SEL_PC4     = 2'b10;
  localparam logic [1:0]      C_ERR_ALIGN   = 2'b01;
  localparam logic [1:0]      C_ERR_FUNCT3  = 2'b10;
  localparam logic [1:0]      C_ERR_TIMEOUT = 2'b11;
  localparam logic [2:0]      C_F3_LB       = 3'b000;
  localparam logic [2:0]      C_F3_LH       = 3'b001;
  localparam logic [2:0]      C_F3_LW       = 3'b010;
  localparam logic [2:0]      C_F3_LBU      = 3'b100;
  localparam logic [2:0]      C_F3_LHU      = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [4:0]        r_ld_rd;
  logic              r_ld_we;
  logic [2:0]        r_ld_funct3;
  logic [1:0]        r_ld_off;

  state_t            w_state_n;
  logic [WC_W-1:0]   w_wait_cnt_n;
  logic [4:0]        w_ld_rd_n;
  logic              w_ld_we_n;
  logic [2:0]        w_ld_funct3_n;
  logic [1:0]        w_ld_off_n;
  logic              w_rf_we_n;
  logic [4:0]        w_rf_a3_n;
  logic [31:0]       w_rf_wd_n;
  logic              w_load_err_n;
  logic [1:0]        w_err_code_n;
  logic [CNT_W-1:0]  w_instret_n;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;

  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  assign w_illegal  = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
  assign w_misalign = (((in_funct3 == C_F3_LH) || (in_funct3 == C_F3_LHU)) && in_alu_result[0]) ||
                      ((in_funct3 == C_F3_LW) && (in_alu_result[1:0] != 2'b00));

  // Lane selection from the latched byte offset of the pending load.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_ld_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_ld_funct3)
      C_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      C_F3_LBU: w_load_data = {24'd0, w_byte};
      C_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      C_F3_LHU: w_load_data = {16'd0, w_half};
      default:  w_load_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_wait_cnt_n  = r_wait_cnt;
    w_ld_rd_n     = r_ld_rd;
    w_ld_we_n     = r_ld_we;
    w_ld_funct3_n = r_ld_funct3;
    w_ld_off_n    = r_ld_off;
    w_rf_we_n     = 1'b0;
    w_rf_a3_n     = rf_a3;
    w_rf_wd_n     = rf_wd;
    w_load_err_n  = 1'b0;
    w_err_code_n  = 2'b00;
    w_instret_n   = instret;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_wb_sel == C_SEL_LOAD) begin
            if (w_illegal) begin
              w_load_err_n = 1'b1;
              w_err_code_n = C_ERR_FUNCT3;
            end else if (w_misalign) begin
              w_load_err_n = 1'b1;
              w_err_code_n = C_ERR_ALIGN;
            end else begin
              w_state_n     = S_WAIT_LOAD;
              w_wait_cnt_n  = '0;
              w_ld_rd_n     = in_rd;
              w_ld_we_n     = in_reg_write;
              w_ld_funct3_n = in_funct3;
              w_ld_off_n    = in_alu_result[1:0];
            end
          end else begin
            // Writes to x0 or with reg_write low still retire.
            w_instret_n = instret + CNT_W'(1);
            if (in_reg_write && (in_rd != 5'd0)) begin
              w_rf_we_n = 1'b1;
              w_rf_a3_n = in_rd;
              w_rf_wd_n = (in_wb_sel == C_SEL_PC4) ? in_pc_plus4 : in_alu_result;
            end
          end
        end
      end

      S_WAIT_LOAD: begin
        if (mem_rvalid) begin
          w_state_n   = S_IDLE;
          w_instret_n = instret + CNT_W'(1);
          if (r_ld_we && (r_ld_rd != 5'd0)) begin
            w_rf_we_n = 1'b1;
            w_rf_a3_n = r_ld_rd;
            w_rf_wd_n = w_load_data;
          end
        end else if (r_wait_cnt == C_WAIT_LAST) begin
          w_state_n    = S_IDLE;
          w_load_err_n = 1'b1;
          w_err_code_n = C_ERR_TIMEOUT;
        end else begin
          w_wait_cnt_n = r_wait_cnt + WC_W'(1);
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_ld_rd     <= 5'd0;
      r_ld_we     <= 1'b0;
      r_ld_funct3 <= 3'd0;
      r_ld_off    <= 2'd0;
      rf_we       <= 1'b0;
      rf_a3       <= 5'd0;
      rf_wd       <= 32'd0;
      load_err    <= 1'b0;
      err_code    <= 2'b00;
      instret     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_wait_cnt  <= w_wait_cnt_n;
      r_ld_rd     <= w_ld_rd_n;
      r_ld_we     <= w_ld_we_n;
      r_ld_funct3 <= w_ld_funct3_n;
      r_ld_off    <= w_ld_off_n;
      rf_we       <= w_rf_we_n;
      rf_a3       <= w_rf_a3_n;
      rf_wd       <= w_rf_wd_n;
      load_err    <= w_load_err_n;
      err_code    <= w_err_code_n;
      instret     <= w_instret_n;
    end
  end

endmodule
`default_nettype wire
